fifo_rd_ctrl: RTL and testbench
===============================

Name: fifo_rd_ctrl

Overview:
Read-side pointer/flag controller for the dual-clock FIFO: the counterpart to the write-side controller. It runs entirely in the read clock domain and receives the write pointer as Gray code from the write domain. It synchronizes that pointer through a flop chain, owns the read pointer, and generates empty, level and underflow status. It drives the read address of the FIFO RAM and returns its own Gray pointer to the write domain.

Parameters:
ADDR_W, 4, RAM address width; FIFO depth = 2**ADDR_W; pointers are ADDR_W+1 bits.
SYNC_STAGES, 2, number of synchronizer flops on wr_ptr_gray; legal range 2..4.
AE_THRESH, 2, almost-empty threshold in entries; used only with ALMOST_EMPTY_EN.

Ports:
clk  input  1  read-domain clock; all state updates on rising edge.
clr_n  input  1  reset, asynchronous, active-low.
rd_en  input  1  pop request from the consumer.
wr_ptr_gray  input  ADDR_W+1  write pointer in Gray code, launched from the write domain and asynchronous to clk.
rd_ptr_gray  output  ADDR_W+1  registered read pointer in Gray code, sent to the write domain.
rd_addr  output  ADDR_W  RAM read address, equal to the low bits of the binary read pointer.
mem_rd_en  output  1  RAM read strobe; equals rd_en & ~empty (combinational).
empty  output  1  registered; high when no entries are visible.
rd_level  output  ADDR_W+1  registered occupancy seen by the read side, range 0..2**ADDR_W.
rd_underflow  output  1  registered one-cycle pulse on a pop attempt while empty.
almost_empty  output  1  registered; see Optional Feature.

Behaviour:
- Reset (clr_n low, async): all synchronizer flops, the binary and Gray read pointers, rd_addr, rd_level and rd_underflow go to 0. empty goes to 1 and almost_empty goes to 1. Outputs change without waiting for a clk edge. Release is synchronous to the next clk edge.
- Synchronizer: wr_ptr_gray passes through a SYNC_STAGES-deep flop chain, giving wq_sync. Only the Gray value crosses the domain; no combinational logic sits in front of the first flop.
- Pop condition: pop = rd_en & ~empty.
  - rd_bin_next = rd_bin + pop, wrapping modulo 2**(ADDR_W+1).
  - rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1).
  - Both pointers are registered; rd_addr = rd_bin[ADDR_W-1:0].
- Empty: the empty register loads (rd_gray_next == wq_sync) each cycle. This gives no extra cycle of empty after the last pop.
- Level: wbin = gray-to-binary(wq_sync); the rd_level register loads wbin - rd_bin_next (modulo 2**(ADDR_W+1)). rd_level = 2**ADDR_W means full as seen by the read side.
- Latency: a write-pointer change on wr_ptr_gray becomes visible on empty/rd_level SYNC_STAGES+1 clk edges later. A pop updates rd_addr, rd_ptr_gray, empty and rd_level on the next edge.
- Underflow: when rd_en & empty, the pointers hold and rd_underflow pulses high for exactly one cycle on the next edge. The pulse is not sticky.
- Simultaneous new write and pop in the same cycle: the pop uses the current empty value; the level reflects both events.
- Wrap-around: binary pointer bit ADDR_W toggles every 2**ADDR_W pops. rd_addr wraps from 2**ADDR_W-1 to 0 with no gap.
- The block does not check whether the write side overruns; rd_level saturation is not applied.

Optional Feature:
ALMOST_EMPTY_EN
- Defined: an almost_empty register loads (next level <= AE_THRESH); it resets to 1.
- Undefined: the almost_empty port is still present and tied to constant 1'b0; there is no threshold logic and the AE_THRESH parameter is unused.

Decomposition:
- Package fifo_cdc_pkg holds:
  - functions bin2gray and gray2bin, parameterized by width;
  - default constants FIFO_ADDR_W=4 and FIFO_SYNC_STAGES=2, shared with the write-side controller.
- One sub-module is natural: gray_ptr_sync, an N-bit by SYNC_STAGES flop chain with clk/clr_n. It is reused unchanged by the write side to synchronize the read pointer.

Test Plan:
- Reset: assert clr_n=0 mid-cycle with rd_level=5 -> immediately empty=1, rd_addr=0, rd_ptr_gray=5'b00000, rd_level=0, without a clk edge.
- Single write visible: wr_ptr_gray 5'b00000 -> 5'b00001 -> empty falls and rd_level=1 exactly 3 edges later (SYNC_STAGES=2).
- Pop to empty plus underflow: with 1 entry, hold rd_en=1 -> mem_rd_en=1 for one cycle; then rd_addr=1, rd_ptr_gray=5'b00001, empty=1 on the next edge; rd_underflow pulses one cycle after that; the pointer holds at 1.
- Wrap: wr binary pointer = 16 (Gray 5'b11000), read pointer at 0; pop 16 times -> rd_level counts 16 down to 0, rd_addr wraps 15 to 0, final rd_ptr_gray=5'b11000, empty=1.
- Full level: wr binary 20 (Gray 5'b11110), rd binary 4 -> rd_level=5'b10000 (16).
- ALMOST_EMPTY_EN with AE_THRESH=2: level 3 -> pop -> almost_empty=1 when level reaches 2. Without the macro, almost_empty stays 0 throughout.

Source files
------------

// File: rtl/fifo_cdc_pkg.sv
// Shared constants and Gray-code helpers for the dual-clock FIFO pointer controllers.
// The helpers take any pointer width up to PTR_MAX_W; callers zero-extend and truncate.
package fifo_cdc_pkg;

    localparam int unsigned FIFO_ADDR_W      = 4;
    localparam int unsigned FIFO_SYNC_STAGES = 2;
    localparam int unsigned PTR_MAX_W        = 32;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero upper bits leave the result unaffected, so one body serves every width.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
        logic [PTR_MAX_W-1:0] bin;
        bin = gray;
        for (int unsigned i = 1; i < PTR_MAX_W; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_gray_ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing clock domains.
// Shared by the read and write controllers; nothing sits in front of the first flop.
module gray_ptr_sync #(
    parameter int unsigned W      = 5,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer/flag controller of the dual-clock FIFO (read clock domain).
// Optional almost-empty flag enabled by defining ALMOST_EMPTY_EN.
module fifo_rd_ctrl
    import fifo_cdc_pkg::*;
#(
    parameter int unsigned ADDR_W      = FIFO_ADDR_W,
    parameter int unsigned SYNC_STAGES = FIFO_SYNC_STAGES,
    parameter int unsigned AE_THRESH   = 2
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   wr_ptr_gray,
    output logic [ADDR_W:0]   rd_ptr_gray,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              mem_rd_en,
    output logic              empty,
    output logic [ADDR_W:0]   rd_level,
    output logic              rd_underflow,
    output logic              almost_empty
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("fifo_rd_ctrl: SYNC_STAGES must be 2..4");
    end
    if (AE_THRESH > (1 << ADDR_W)) begin : g_bad_ae
        $error("fifo_rd_ctrl: AE_THRESH exceeds FIFO depth");
    end

    logic [PTR_W-1:0] wq_sync;
    logic [PTR_W-1:0] rd_bin;
    logic [PTR_W-1:0] rd_bin_next;
    logic [PTR_W-1:0] rd_gray_next;
    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] level_next;
    logic             pop;
    logic             empty_next;

    gray_ptr_sync #(
        .W      (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk   (clk),
        .clr_n (clr_n),
        .d     (wr_ptr_gray),
        .q     (wq_sync)
    );

    // Next-pointer and flag computation; empty compares in Gray, level in binary.
    always_comb begin
        pop          = rd_en & ~empty;
        rd_bin_next  = rd_bin + PTR_W'(pop);
        rd_gray_next = PTR_W'(bin2gray(PTR_MAX_W'(rd_bin_next)));
        wbin         = PTR_W'(gray2bin(PTR_MAX_W'(wq_sync)));
        level_next   = wbin - rd_bin_next;
        empty_next   = (rd_gray_next == wq_sync);
    end

    assign mem_rd_en = pop;
    assign rd_addr   = rd_bin[ADDR_W-1:0];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rd_bin       <= '0;
            rd_ptr_gray  <= '0;
            empty        <= 1'b1;
            rd_level     <= '0;
            rd_underflow <= 1'b0;
        end else begin
            rd_bin       <= rd_bin_next;
            rd_ptr_gray  <= rd_gray_next;
            empty        <= empty_next;
            rd_level     <= level_next;
            rd_underflow <= rd_en & empty;
        end
    end

`ifdef ALMOST_EMPTY_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            almost_empty <= 1'b1;
        end else begin
            almost_empty <= (PTR_MAX_W'(level_next) <= PTR_MAX_W'(AE_THRESH));
        end
    end
`else
    assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: occupancy model from write/read counts plus directed literals.
module tb_fifo_rd_ctrl;

    localparam int ADDR_W = 4;
    localparam int SYNC   = 2;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PMOD   = 2 * DEPTH;
    localparam int AE_TH  = 2;

    logic              clk = 1'b0;
    logic              clr_n = 1'b0;
    logic              rd_en = 1'b0;
    logic [ADDR_W:0]   wr_ptr_gray = '0;
    logic [ADDR_W:0]   rd_ptr_gray;
    logic [ADDR_W-1:0] rd_addr;
    logic              mem_rd_en;
    logic              empty;
    logic [ADDR_W:0]   rd_level;
    logic              rd_underflow;
    logic              almost_empty;

    int total  = 0;
    int passed = 0;

    fifo_rd_ctrl #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC), .AE_THRESH(AE_TH)) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .rd_en        (rd_en),
        .wr_ptr_gray  (wr_ptr_gray),
        .rd_ptr_gray  (rd_ptr_gray),
        .rd_addr      (rd_addr),
        .mem_rd_en    (mem_rd_en),
        .empty        (empty),
        .rd_level     (rd_level),
        .rd_underflow (rd_underflow),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int gray_of(input int n);
        int m;
        m = n % PMOD;
        return m ^ (m >> 1);
    endfunction

    // Model: entries visible = writes seen SYNC edges ago minus reads done.
    int wr_cnt = 0;
    int hist [8];
    int cyc = 0;
    int m_rd = 0;
    int m_level = 0;
    bit m_empty = 1'b1;
    bit m_uf = 1'b0;
    bit m_ae;
    bit model_on = 1'b1;

    initial begin
        for (int i = 0; i < 8; i++) hist[i] = 0;
`ifdef ALMOST_EMPTY_EN
        m_ae = 1'b1;
`else
        m_ae = 1'b0;
`endif
    end

    always @(posedge clk) begin
        int vis;
        if (!clr_n) begin
            for (int i = 0; i < 8; i++) hist[i] = 0;
            m_rd = 0; m_level = 0; m_empty = 1'b1; m_uf = 1'b0;
`ifdef ALMOST_EMPTY_EN
            m_ae = 1'b1;
`endif
        end else begin
            vis = hist[(cyc - SYNC) & 7];
            hist[cyc & 7] = wr_cnt;
            cyc++;
            m_uf = rd_en && m_empty;
            if (rd_en && !m_empty) m_rd++;
            m_level = (((vis - m_rd) % PMOD) + PMOD) % PMOD;
            m_empty = (m_level == 0);
`ifdef ALMOST_EMPTY_EN
            m_ae = (m_level <= AE_TH);
`endif
        end
        #1;
        if (model_on) begin
            chk("m_empty", int'(empty), int'(m_empty));
            chk("m_level", int'(rd_level), m_level);
            chk("m_rd_addr", int'(rd_addr), m_rd % DEPTH);
            chk("m_rd_gray", int'(rd_ptr_gray), gray_of(m_rd));
            chk("m_underflow", int'(rd_underflow), int'(m_uf));
            chk("m_mem_rd_en", int'(mem_rd_en), int'(rd_en && !m_empty));
            chk("m_almost_empty", int'(almost_empty), int'(m_ae));
        end
    end

    task automatic set_wr(input int n);
        wr_cnt = n;
        wr_ptr_gray = (ADDR_W+1)'(gray_of(n));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        set_wr(0);
        rd_en = 1'b0;
        tick(2);
        clr_n = 1'b1;
    endtask

    initial begin
        int ae_exp;
        // Reset state
        do_reset();
        #1;
        chk("rst_empty", int'(empty), 1);
        chk("rst_level", int'(rd_level), 0);
        chk("rst_addr", int'(rd_addr), 0);
        chk("rst_gray", int'(rd_ptr_gray), 0);
        chk("rst_uf", int'(rd_underflow), 0);
`ifdef ALMOST_EMPTY_EN
        ae_exp = 1;
`else
        ae_exp = 0;
`endif
        chk("rst_ae", int'(almost_empty), ae_exp);
        tick(1);

        // Single write becomes visible after SYNC+1 edges
        set_wr(1);
        tick(1); chk("wr1_e1_empty", int'(empty), 1);
        tick(1); chk("wr1_e2_empty", int'(empty), 1);
        tick(1); chk("wr1_e3_empty", int'(empty), 0);
        chk("wr1_e3_level", int'(rd_level), 1);

        // Pop the single entry, then underflow
        rd_en = 1'b1;
        #1 chk("pop_mem_rd_en", int'(mem_rd_en), 1);
        tick(1);
        chk("pop_addr", int'(rd_addr), 1);
        chk("pop_gray", int'(rd_ptr_gray), 5'b00001);
        chk("pop_empty", int'(empty), 1);
        chk("pop_mem_rd_en_off", int'(mem_rd_en), 0);
        tick(1);
        chk("uf_pulse", int'(rd_underflow), 1);
        chk("uf_addr_hold", int'(rd_addr), 1);
        rd_en = 1'b0;
        tick(1);
        chk("uf_clear", int'(rd_underflow), 0);

        // Mid-cycle async reset with level 5
        set_wr(6);
        tick(3);
        chk("pre_rst_level", int'(rd_level), 5);
        #2 clr_n = 1'b0;
        #1;
        chk("async_empty", int'(empty), 1);
        chk("async_addr", int'(rd_addr), 0);
        chk("async_gray", int'(rd_ptr_gray), 5'b00000);
        chk("async_level", int'(rd_level), 0);
        do_reset();
        tick(1);

        // Wrap: 16 entries, pop them all
        set_wr(16);
        chk("wrap_gray_in", int'(wr_ptr_gray), 5'b11000);
        tick(3);
        chk("wrap_level16", int'(rd_level), 16);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            chk("wrap_level", int'(rd_level), 15 - i);
            chk("wrap_addr", int'(rd_addr), (i + 1) % 16);
        end
        rd_en = 1'b0;
        chk("wrap_final_gray", int'(rd_ptr_gray), 5'b11000);
        chk("wrap_final_empty", int'(empty), 1);

        // Level 3, then simultaneous write and pops through to underflow
        set_wr(19);
        tick(3);
        chk("lvl3", int'(rd_level), 3);
        chk("lvl3_ae", int'(almost_empty), 0);
        rd_en = 1'b1;
        set_wr(20);
        tick(1);
        chk("lvl2", int'(rd_level), 2);
`ifdef ALMOST_EMPTY_EN
        chk("lvl2_ae", int'(almost_empty), 1);
`else
        chk("lvl2_ae", int'(almost_empty), 0);
`endif
        tick(7);
        rd_en = 1'b0;
        chk("sim_drain_empty", int'(empty), 1);
        chk("sim_drain_addr", int'(rd_addr), 4);
        tick(1);

        // Full level as seen by the read side: wr=20, rd=4
        do_reset();
        set_wr(4);
        tick(3);
        rd_en = 1'b1;
        tick(4);
        rd_en = 1'b0;
        chk("full_pre_gray", int'(rd_ptr_gray), 5'b00110);
        set_wr(20);
        chk("full_gray_in", int'(wr_ptr_gray), 5'b11110);
        tick(3);
        chk("full_level", int'(rd_level), 16);
        chk("full_not_empty", int'(empty), 0);
        tick(2);

        model_on = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
